// File: rtl/pwm_capture_pkg.sv
// Shared servo timing constants and capture types for the PWM receive path.
// Defaults match the servo driver so a looped-back link measures in range.
package pwm_capture_pkg;

   localparam int unsigned SERVO_MIN_WIDTH = 100_000;
   localparam int unsigned SERVO_MAX_WIDTH = 200_000;
   localparam int unsigned SERVO_PERIOD    = 2_000_000;
   localparam int unsigned CAP_TIMEOUT     = 2 * SERVO_PERIOD;

   localparam int CNT_W = 32;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      cnt_t width;
      cnt_t period;
      logic range_err;
   } meas_t;

   function automatic logic out_of_range(input cnt_t w, input cnt_t lo, input cnt_t hi);
      return (w < lo) || (w > hi);
   endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer plus delay flop; rise/fall are one-cycle pulses on pwm_s.
// Latency 2 cycles pin-to-pwm_s; no backpressure. o_ready marks a fully refilled chain.
module pwm_sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pwm,
   output logic o_pwm_s,
   output logic o_rise,
   output logic o_fall,
   output logic o_ready
);

   logic       r_meta;
   logic       r_sync;
   logic       r_dly;
   logic [1:0] r_prime;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_dly   <= 1'b0;
         r_prime <= 2'd0;
      end else begin
         r_meta <= i_pwm;
         r_sync <= r_meta;
         r_dly  <= r_sync;
         // pwm_s only reflects the pin once both stages have refilled after reset
         if (r_prime != 2'd2) begin
            r_prime <= r_prime + 2'd1;
         end
      end
   end

   assign o_pwm_s = r_sync;
   assign o_rise  = r_sync & ~r_dly;
   assign o_fall  = ~r_sync & r_dly;
   assign o_ready = (r_prime == 2'd2);

endmodule

// File: rtl/pwm_capture.sv
// Servo PWM receiver: reports high time and rise-to-rise period once per period, with range and loss flags.
// valid rises 3 cycles after the pin rise is first sampled; no backpressure, reports are strobes.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int unsigned MIN_WIDTH = SERVO_MIN_WIDTH,
   parameter int unsigned MAX_WIDTH = SERVO_MAX_WIDTH,
   parameter int unsigned TIMEOUT   = CAP_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pwm_in,
   output logic [31:0] width,
   output logic [31:0] period,
   output logic        valid,
   output logic        range_err,
   output logic        lost
);

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_WAIT_RISE,
      ST_MEAS_HIGH,
      ST_MEAS_LOW
   } state_t;

   state_t r_state;
   state_t w_next;

   logic   w_pwm_s;
   logic   w_rise;
   logic   w_fall;
   logic   w_ready;
   logic   w_per_sat;

   logic   w_start;
   logic   w_report;
   logic   w_lose;
   logic   w_hi_inc;
   logic   w_per_inc;

   cnt_t   r_hi_cnt;
   cnt_t   r_per_cnt;
   meas_t  r_meas;
   logic   r_valid;
   logic   r_lost;

   pwm_sync_edge u_sync (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_pwm   (pwm_in),
      .o_pwm_s (w_pwm_s),
      .o_rise  (w_rise),
      .o_fall  (w_fall),
      .o_ready (w_ready)
   );

   assign w_per_sat = (r_per_cnt == cnt_t'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_SYNC;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_SYNC: begin
            if (w_ready && !w_pwm_s) begin
               w_next = ST_WAIT_RISE;
            end
         end
         ST_WAIT_RISE: begin
            if (w_rise) begin
               w_next = ST_MEAS_HIGH;
            end
         end
         ST_MEAS_HIGH: begin
            if (w_per_sat) begin
               w_next = ST_SYNC;
            end else if (w_fall) begin
               w_next = ST_MEAS_LOW;
            end
         end
         ST_MEAS_LOW: begin
            // a rise landing on the saturated count still counts as a legal period
            if (w_rise) begin
               w_next = ST_MEAS_HIGH;
            end else if (w_per_sat) begin
               w_next = ST_SYNC;
            end
         end
         default: w_next = ST_SYNC;
      endcase
   end

   always_comb begin
      w_start   = 1'b0;
      w_report  = 1'b0;
      w_lose    = 1'b0;
      w_hi_inc  = 1'b0;
      w_per_inc = 1'b0;
      case (r_state)
         ST_WAIT_RISE: begin
            w_start = w_rise;
         end
         ST_MEAS_HIGH: begin
            w_lose    = w_per_sat & ~w_rise;
            w_hi_inc  = ~w_fall & ~w_per_sat;
            w_per_inc = ~w_per_sat;
         end
         ST_MEAS_LOW: begin
            w_start   = w_rise;
            w_report  = w_rise;
            w_lose    = w_per_sat & ~w_rise;
            w_per_inc = ~w_rise & ~w_per_sat;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi_cnt  <= '0;
         r_per_cnt <= '0;
         r_meas    <= '0;
         r_valid   <= 1'b0;
         r_lost    <= 1'b1;
      end else begin
         r_valid <= w_report;
         if (w_start) begin
            r_hi_cnt  <= cnt_t'(1);
            r_per_cnt <= cnt_t'(1);
         end else begin
            if (w_hi_inc) begin
               r_hi_cnt <= r_hi_cnt + cnt_t'(1);
            end
            if (w_per_inc) begin
               r_per_cnt <= r_per_cnt + cnt_t'(1);
            end
         end
         if (w_report) begin
            r_meas.width     <= r_hi_cnt;
            r_meas.period    <= r_per_cnt;
            r_meas.range_err <= out_of_range(r_hi_cnt, cnt_t'(MIN_WIDTH), cnt_t'(MAX_WIDTH));
         end
         if (w_report) begin
            r_lost <= 1'b0;
         end else if (w_lose) begin
            r_lost <= 1'b1;
         end
      end
   end

   assign width     = r_meas.width;
   assign period    = r_meas.period;
   assign range_err = r_meas.range_err;
   assign valid     = r_valid;
   assign lost      = r_lost;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed + randomized bench for pwm_capture; the reference model works on pin-level
// rise/fall timestamps and predicts outputs three cycles later.
module tb_pwm_capture;

   localparam int MINW = 10;
   localparam int MAXW = 20;
   localparam int TO   = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pwm_in = 1'b0;
   logic [31:0] width;
   logic [31:0] period;
   logic        valid;
   logic        range_err;
   logic        lost;

   pwm_capture #(
      .MIN_WIDTH (MINW),
      .MAX_WIDTH (MAXW),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pwm_in    (pwm_in),
      .width     (width),
      .period    (period),
      .valid     (valid),
      .range_err (range_err),
      .lost      (lost)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic vld;
      int   w;
      int   p;
      logic re;
      logic ls;
   } snap_t;

   typedef enum {M_SYNC, M_ARM, M_MEAS} mmode_t;

   snap_t  dl[$];
   snap_t  cur;
   mmode_t mode;
   int     t_rise;
   int     t_fall;
   bit     fell;
   logic   m_prev;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     n_valid  = 0;
   int     last_pin_rise = -100;
   logic   pin_prev = 1'b0;
   int     last_period = 0;
   logic   re_log[$];
   int     mark;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic snap_t reset_snap();
      snap_t s;
      s.vld = 1'b0;
      s.w   = 0;
      s.p   = 0;
      s.re  = 1'b0;
      s.ls  = 1'b1;
      return s;
   endfunction

   task automatic model_reset();
      dl.delete();
      cur = reset_snap();
      repeat (3) dl.push_back(cur);
      mode   = M_SYNC;
      m_prev = 1'b0;
   endtask

   // Pin cycle n determines the outputs seen in cycle n+3.
   task automatic model_step(input logic v);
      logic rise;
      rise    = v & ~m_prev;
      cur.vld = 1'b0;
      case (mode)
         M_SYNC: if (!v) mode = M_ARM;
         M_ARM: begin
            if (rise) begin
               mode   = M_MEAS;
               t_rise = cyc;
               fell   = 1'b0;
            end
         end
         M_MEAS: begin
            if (rise) begin
               cur.vld = 1'b1;
               cur.w   = t_fall - t_rise;
               cur.p   = cyc - t_rise;
               cur.re  = (cur.w < MINW) || (cur.w > MAXW);
               cur.ls  = 1'b0;
               t_rise  = cyc;
               fell    = 1'b0;
            end else if (cyc - t_rise == TO) begin
               cur.ls = 1'b1;
               mode   = M_SYNC;
            end else if (!v && !fell) begin
               fell   = 1'b1;
               t_fall = cyc;
            end
         end
         default: ;
      endcase
      m_prev = v;
      dl.push_back(cur);
   endtask

   task automatic tick(input logic v, input logic r);
      snap_t e;
      @(posedge clk);
      #1;
      e = dl.pop_front();
      chk("valid", valid, e.vld);
      chk("lost", lost, e.ls);
      chk("width", width, e.w);
      chk("period", period, e.p);
      chk("range_err", range_err, e.re);
      if (valid) begin
         n_valid++;
         last_period = period;
         re_log.push_back(range_err);
         chk("latency", cyc - last_pin_rise, 3);
      end
      pwm_in = v;
      rst    = r;
      if (!r && v && !pin_prev) last_pin_rise = cyc;
      pin_prev = v;
      if (r) model_reset();
      else   model_step(v);
      cyc++;
   endtask

   task automatic pulse(input int w, input int p);
      for (int i = 0; i < p; i++) tick(i < w, 1'b0);
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) tick(v, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int p;
      model_reset();
      cur = reset_snap();

      repeat (4) tick(1'b0, 1'b1);
      chk("rst_width", width, 0);
      chk("rst_period", period, 0);
      chk("rst_valid", valid, 0);
      chk("rst_range_err", range_err, 0);
      chk("rst_lost", lost, 1);
      hold(1'b0, 5);

      // servo-driver waveform: high 15, counter 0..200
      mark = n_valid;
      repeat (4) pulse(15, 201);
      chk("first4_valids", n_valid - mark, 3);
      chk("first4_lost", lost, 0);
      chk("first4_period", period, 201);

      re_log.delete();
      pulse(9, 201);
      pulse(10, 201);
      pulse(20, 201);
      pulse(21, 201);
      pulse(15, 201);
      chk("range_log_size", re_log.size(), 5);
      chk("range_w9", re_log[1], 1);
      chk("range_w10", re_log[2], 0);
      chk("range_w20", re_log[3], 0);
      chk("range_w21", re_log[4], 1);

      for (int k = 0; k < 20; k++) begin
         w = int'($urandom_range(1, 28));
         p = int'($urandom_range(30, 390));
         pulse(w, p);
      end

      // stuck low
      repeat (3) pulse(15, 201);
      mark = n_valid;
      hold(1'b0, 500);
      chk("low_no_valid", n_valid - mark, 0);
      chk("low_lost", lost, 1);
      chk("low_width", width, 15);
      chk("low_period", period, 201);
      mark = n_valid;
      repeat (3) pulse(15, 201);
      chk("low_resume_valids", n_valid - mark, 2);

      // stuck high
      hold(1'b1, 500);
      chk("high_lost", lost, 1);
      hold(1'b0, 50);
      mark = n_valid;
      repeat (3) pulse(15, 201);
      chk("high_resume_valids", n_valid - mark, 2);

      // reset mid-high
      hold(1'b1, 5);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      chk("midrst_lost", lost, 1);
      chk("midrst_width", width, 0);
      chk("midrst_period", period, 0);
      hold(1'b1, 10);
      hold(1'b0, 186);
      mark = n_valid;
      repeat (3) pulse(15, 201);
      chk("midrst_valids", n_valid - mark, 2);

      // rise exactly at the timeout count
      repeat (3) pulse(15, 400);
      hold(1'b1, 5);
      chk("p400_period", last_period, 400);
      chk("p400_lost", lost, 0);
      hold(1'b1, 10);
      hold(1'b0, 100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming servo-style PWM waveform. It reports the high time and the period, in clk cycles, once per complete period. It is the receive end of the servo PWM link, used for closed-loop checks of driver output and for decoding RC/external servo commands. A range flag checks the measured width against the servo pulse limits, and a sticky loss-of-signal flag covers a stuck or absent input.

Parameters:
MIN_WIDTH, 100000, minimum legal high time in cycles (1.0 ms at 100 MHz)
MAX_WIDTH, 200000, maximum legal high time in cycles (2.0 ms at 100 MHz)
TIMEOUT, 4000000, cycles without a rising edge before loss of signal is declared

Ports:
clk  in  1  system clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
pwm_in  in  1  asynchronous PWM input
width  out  32  latched high time of the last complete period, in cycles
period  out  32  latched rise-to-rise period, in cycles
valid  out  1  one-cycle strobe; width/period/range_err updated this cycle
range_err  out  1  latched with valid: 1 if width < MIN_WIDTH or width > MAX_WIDTH
lost  out  1  sticky loss-of-signal level

Behaviour:
- Reset (rst=1 at posedge): width=0, period=0, valid=0, range_err=0, lost=1. Synchronizer flops=0, counters=0, state=SYNC. Reset mid-measurement discards the partial period.
- Input: 2-flop synchronizer gives pwm_s; prev flop gives pwm_d. rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
- Counters: hi_cnt and per_cnt, both 32-bit. per_cnt saturates at TIMEOUT.
- States:
  SYNC: wait for pwm_s=0, then go to WAIT_RISE. This avoids measuring a partial pulse after reset or loss.
  WAIT_RISE: on rise, set hi_cnt=1 and per_cnt=1, go to MEAS_HIGH. No report is made.
  MEAS_HIGH: each cycle with pwm_s=1, increment hi_cnt and per_cnt. On fall, increment per_cnt only (hi_cnt frozen) and go to MEAS_LOW.
  MEAS_LOW: increment per_cnt each cycle. On rise, report (below), set hi_cnt=1 and per_cnt=1, stay in the measuring loop (go to MEAS_HIGH).
- Report, at the clock edge where rise is seen in MEAS_LOW:
  - width <= hi_cnt, period <= per_cnt, valid <= 1 for one cycle.
  - range_err <= (hi_cnt < MIN_WIDTH) | (hi_cnt > MAX_WIDTH).
  - lost <= 0.
- Latency: valid is high in the 3rd clk cycle after the pin rise is first sampled (2 sync stages + 1 output register).
- Timeout: in MEAS_HIGH or MEAS_LOW, if per_cnt == TIMEOUT and there is no rise this cycle, then lost <= 1, state -> SYNC, no valid.
  - Covers both stuck-high and stuck-low inputs.
  - A rise coinciding with per_cnt == TIMEOUT reports normally (period = TIMEOUT is legal).
- lost stays 1 until the next valid report. The first complete period after SYNC always needs two rises.
- width and period hold their last values between reports, and through loss of signal.
- Minimum measurable values: width >= 1, period >= 2. A single-cycle glitch is reported as-is, with range_err=1.
- Waveform from the servo driver (high for W cycles, counter 0..P inclusive) measures width=W, period=P+1.

Decomposition:
- Shared servo defines header: min_width, max_width, period. These are the same constants as the servo driver and serve as the defaults for MIN_WIDTH/MAX_WIDTH. TIMEOUT defaults to 2x period.
- State encodings are local to the module.
- One sub-module: pwm_sync_edge (2-flop synchronizer + pwm_d register; outputs pwm_s, rise, fall; synchronous rst clears all flops to 0).

Test Plan (bench overrides MIN_WIDTH=10, MAX_WIDTH=20, TIMEOUT=400):
- Drive a servo-driver-style waveform, high 15, period counter 0..200 (201 cycles), 4 periods:
  - First valid after the 2nd rise: width=15, period=201, range_err=0.
  - lost 1->0 at that valid; a valid every 201 cycles thereafter.
- Widths 9, 10, 20, 21 with period 201 -> range_err = 1, 0, 0, 1 respectively.
- Hold pwm_in low after steady pulses:
  - lost=1 exactly when per_cnt hits 400; no further valid.
  - width=15 and period=201 retained.
  - Resume pulses -> first valid on the 2nd rise.
- Hold pwm_in high for 500 cycles:
  - lost=1 at 400, state SYNC.
  - After the input falls, the next valid comes only after two further rises.
- Assert rst for 1 cycle mid-MEAS_HIGH:
  - All outputs return to reset values, lost=1.
  - The partial pulse is not reported.
  - The next report is correct on the 2nd full rise.
- Rise arriving exactly at per_cnt=400 -> valid with period=400, lost stays 0.
- Latency check: valid is high in the 3rd cycle after the pin rise.
